// File: rtl/dcm_reset_sequencer_if.sv
// Signal bundle between the DCM reset sequencer and the DCM / clock-domain logic.
// The sequencer side uses the master modport.
// All signals are plain levels with no handshake:
//   LOCKED_IN comes from the DCM.
//   The rest are registered control/status outputs of the sequencer.
interface dcm_reset_sequencer_if #(
    parameter int MAX_RETRIES = 3
);
    localparam int RW = $clog2(MAX_RETRIES + 1);

    logic          LOCKED_IN;
    logic          DCM_RST_OUT;
    logic          SYS_RST_OUT;
    logic          READY_OUT;
    logic          FAIL_OUT;
    logic [RW-1:0] RETRY_CNT_OUT;

    modport master (
        input  LOCKED_IN,
        output DCM_RST_OUT,
        output SYS_RST_OUT,
        output READY_OUT,
        output FAIL_OUT,
        output RETRY_CNT_OUT
    );

    modport slave (
        output LOCKED_IN,
        input  DCM_RST_OUT,
        input  SYS_RST_OUT,
        input  READY_OUT,
        input  FAIL_OUT,
        input  RETRY_CNT_OUT
    );
endinterface

// File: rtl/dcm_reset_sequencer.sv
// DCM reset sequencer.
// Sequence: pulse the DCM reset, wait for LOCKED, then qualify lock over a stability window.
// After that the system reset is released.
// A lock timeout re-runs the sequence. Timeouts are bounded by MAX_RETRIES, after which the
// sequencer sits in FAIL until RST_IN.
// Loss of lock in RUN re-runs the sequence without charging a retry.
// Clocked from the DCM input clock.
// Optional feature macro: LOCK_SYNC_EN
//   Routes LOCKED_IN through a 2-flop synchronizer.
//   The synchronizer is held clear while the DCM is in reset, so a stale LOCKED from the previous
//   DCM run cannot qualify the new one.
module dcm_reset_sequencer #(
    parameter int RST_CYCLES   = 4,
    parameter int LOCK_TIMEOUT = 1000,
    parameter int LOCK_STABLE  = 16,
    parameter int MAX_RETRIES  = 3
) (
    input  logic                        CLKIN_IN,
    input  logic                        RST_IN,
    dcm_reset_sequencer_if.master       seq,
    output logic [2:0]                  dbg_state_o
);
    localparam int CNT_MAX0 = (LOCK_TIMEOUT > LOCK_STABLE) ? LOCK_TIMEOUT : LOCK_STABLE;
    localparam int CNT_MAX  = (CNT_MAX0 > RST_CYCLES) ? CNT_MAX0 : RST_CYCLES;
    localparam int CW       = $clog2(CNT_MAX + 1);
    localparam int RW       = $clog2(MAX_RETRIES + 1);

    localparam logic [CW-1:0] CNT_SAT   = CW'(CNT_MAX);
    localparam logic [CW-1:0] PULSE_END = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] TO_END    = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] STB_END   = CW'(LOCK_STABLE - 1);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_PULSE  = 3'd0,
        S_WAIT   = 3'd1,
        S_STABLE = 3'd2,
        S_RUN    = 3'd3,
        S_FAIL   = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [RW-1:0] retry_q, retry_d, retry_inc;
    logic          dcm_rst_q, dcm_rst_d;
    logic          sys_rst_q, sys_rst_d;
    logic          ready_q, ready_d;
    logic          fail_q, fail_d;
    logic          lk;

`ifdef LOCK_SYNC_EN
    logic [1:0] sync_q;

    // Two-flop synchronizer for LOCKED_IN; cleared while the DCM reset is driven.
    always_ff @(posedge CLKIN_IN or posedge RST_IN) begin
        if (RST_IN) begin
            sync_q <= 2'b00;
        end else if (dcm_rst_q) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], seq.LOCKED_IN};
        end
    end

    assign lk = sync_q[1];
`else
    assign lk = seq.LOCKED_IN;
`endif

    // State, counter and registered outputs.
    always_ff @(posedge CLKIN_IN or posedge RST_IN) begin
        if (RST_IN) begin
            state_q   <= S_PULSE;
            cnt_q     <= '0;
            retry_q   <= '0;
            dcm_rst_q <= 1'b1;
            sys_rst_q <= 1'b1;
            ready_q   <= 1'b0;
            fail_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            retry_q   <= retry_d;
            dcm_rst_q <= dcm_rst_d;
            sys_rst_q <= sys_rst_d;
            ready_q   <= ready_d;
            fail_q    <= fail_d;
        end
    end

    // Next state, saturating counter/retry updates, and outputs decoded from the next state.
    always_comb begin
        state_d   = state_q;
        cnt_d     = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + 1'b1;
        retry_d   = retry_q;
        retry_inc = (retry_q == RETRY_MAX) ? retry_q : retry_q + 1'b1;

        case (state_q)
            S_PULSE: begin
                if (cnt_q == PULSE_END) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // Lock seen on the timeout cycle takes priority over the timeout.
                if (lk) begin
                    state_d = S_STABLE;
                end else if (cnt_q == TO_END) begin
                    retry_d = retry_inc;
                    state_d = (retry_inc == RETRY_MAX) ? S_FAIL : S_PULSE;
                end
            end
            S_STABLE: begin
                if (!lk) begin
                    state_d = S_WAIT;
                end else if (cnt_q == STB_END) begin
                    state_d = S_RUN;
                    retry_d = '0;
                end
            end
            S_RUN: begin
                if (!lk) begin
                    state_d = S_PULSE;
                end
            end
            S_FAIL: begin
                state_d = S_FAIL;
            end
            default: begin
                state_d = S_PULSE;
            end
        endcase

        // Each state measures its own window from zero.
        if (state_d != state_q) begin
            cnt_d = '0;
        end

        dcm_rst_d = (state_d == S_PULSE) || (state_d == S_FAIL);
        sys_rst_d = (state_d != S_RUN);
        ready_d   = (state_d == S_RUN);
        fail_d    = (state_d == S_FAIL);
    end

    assign seq.DCM_RST_OUT   = dcm_rst_q;
    assign seq.SYS_RST_OUT   = sys_rst_q;
    assign seq.READY_OUT     = ready_q;
    assign seq.FAIL_OUT      = fail_q;
    assign seq.RETRY_CNT_OUT = retry_q;
    assign dbg_state_o       = state_q;
endmodule

// File: tb/tb_dcm_reset_sequencer.sv
// Testbench for dcm_reset_sequencer (default build, LOCK_SYNC_EN undefined).
module tb_dcm_reset_sequencer;
  localparam int RST_CYCLES   = 4;
  localparam int LOCK_TIMEOUT = 1000;
  localparam int LOCK_STABLE  = 16;
  localparam int MAX_RETRIES  = 3;
  localparam int RW           = $clog2(MAX_RETRIES + 1);

  localparam int PH_PULSE  = 0;
  localparam int PH_WAIT   = 1;
  localparam int PH_STABLE = 2;
  localparam int PH_RUN    = 3;
  localparam int PH_FAIL   = 4;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] dbg_state;

  always #5 clk = ~clk;

  dcm_reset_sequencer_if #(.MAX_RETRIES(MAX_RETRIES)) bus();

  dcm_reset_sequencer #(
    .RST_CYCLES  (RST_CYCLES),
    .LOCK_TIMEOUT(LOCK_TIMEOUT),
    .LOCK_STABLE (LOCK_STABLE),
    .MAX_RETRIES (MAX_RETRIES)
  ) dut (
    .CLKIN_IN   (clk),
    .RST_IN     (rst),
    .seq        (bus.master),
    .dbg_state_o(dbg_state)
  );

  int checks = 0;
  int errors = 0;

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic e_dcm, input logic e_sys,
                       input logic e_rdy, input logic e_fail, input logic [RW-1:0] e_rc);
    checks++;
    if (bus.DCM_RST_OUT !== e_dcm || bus.SYS_RST_OUT !== e_sys || bus.READY_OUT !== e_rdy ||
        bus.FAIL_OUT !== e_fail || bus.RETRY_CNT_OUT !== e_rc) begin
      errors++;
      $display("FAIL %s t=%0t: got dcm=%b sys=%b rdy=%b fail=%b rc=%0d, expected dcm=%b sys=%b rdy=%b fail=%b rc=%0d",
               name, $time, bus.DCM_RST_OUT, bus.SYS_RST_OUT, bus.READY_OUT, bus.FAIL_OUT,
               bus.RETRY_CNT_OUT, e_dcm, e_sys, e_rdy, e_fail, e_rc);
    end
  endtask

  task automatic check_reset_vals(input string name);
    check(name, 1'b1, 1'b1, 1'b0, 1'b0, '0);
  endtask

  // ---------------- driver ----------------
  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    edges(2);
    rst = 1'b0;
  endtask

  // ---------------- table vectors ----------------
  typedef struct {
    logic          rst;
    logic          lk;
    int            cycles;
    logic          dcm;
    logic          sys;
    logic          rdy;
    logic          fl;
    logic [RW-1:0] rc;
    string         name;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic r, input logic l, input int c, input logic d,
                         input logic s, input logic y, input logic f,
                         input logic [RW-1:0] rc, input string n);
    vec_t v;
    v.rst = r; v.lk = l; v.cycles = c; v.dcm = d; v.sys = s; v.rdy = y; v.fl = f;
    v.rc = rc; v.name = n;
    vecs.push_back(v);
  endtask

  // ---------------- reference model ----------------
  // Tracks the lock sequence in terms of elapsed edges per phase.
  int m_phase, m_elapsed, m_streak, m_retry;

  task automatic model_reset();
    m_phase = PH_PULSE; m_elapsed = 0; m_streak = 0; m_retry = 0;
  endtask

  task automatic model_edge(input logic lk);
    case (m_phase)
      PH_PULSE: begin
        m_elapsed++;
        if (m_elapsed == RST_CYCLES) begin m_phase = PH_WAIT; m_elapsed = 0; end
      end
      PH_WAIT: begin
        if (lk) begin
          m_phase = PH_STABLE; m_streak = 0;
        end else begin
          m_elapsed++;
          if (m_elapsed == LOCK_TIMEOUT) begin
            if (m_retry < MAX_RETRIES) m_retry++;
            m_phase = (m_retry == MAX_RETRIES) ? PH_FAIL : PH_PULSE;
            m_elapsed = 0;
          end
        end
      end
      PH_STABLE: begin
        if (!lk) begin
          m_phase = PH_WAIT; m_elapsed = 0;
        end else begin
          m_streak++;
          if (m_streak == LOCK_STABLE) begin m_phase = PH_RUN; m_retry = 0; end
        end
      end
      PH_RUN: begin
        if (!lk) begin m_phase = PH_PULSE; m_elapsed = 0; end
      end
      default: ;
    endcase
  endtask

  task automatic check_model(input string name);
    check(name, (m_phase == PH_PULSE) || (m_phase == PH_FAIL), m_phase != PH_RUN,
          m_phase == PH_RUN, m_phase == PH_FAIL, RW'(m_retry));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

  // ---------------- main test ----------------
  initial begin
    rst = 1'b1;
    bus.LOCKED_IN = 1'b1;
    #1;

    // Lock tied high from reset, then a one-cycle lock loss in RUN.
    add_vec(1, 1, 2,  1, 1, 0, 0, 0, "reset_hold");
    add_vec(0, 1, 3,  1, 1, 0, 0, 0, "pulse_edge3");
    add_vec(0, 1, 1,  0, 1, 0, 0, 0, "dcm_release_edge4");
    add_vec(0, 1, 16, 0, 1, 0, 0, 0, "still_reset_edge20");
    add_vec(0, 1, 1,  0, 0, 1, 0, 0, "run_edge21");
    add_vec(0, 1, 5,  0, 0, 1, 0, 0, "run_hold");
    add_vec(0, 0, 1,  1, 1, 0, 0, 0, "lockloss_pulse");
    add_vec(0, 1, 3,  1, 1, 0, 0, 0, "lockloss_pulse_4cyc");
    add_vec(0, 1, 1,  0, 1, 0, 0, 0, "lockloss_dcm_release");
    add_vec(0, 1, 17, 0, 0, 1, 0, 0, "relock_run");
    // Glitch during STABLE: 10 locked, 1 unlocked, then locked.
    add_vec(1, 1, 2,  1, 1, 0, 0, 0, "glitch_reset");
    add_vec(0, 1, 10, 0, 1, 0, 0, 0, "glitch_stable");
    add_vec(0, 0, 1,  0, 1, 0, 0, 0, "glitch_drop");
    add_vec(0, 1, 16, 0, 1, 0, 0, 0, "glitch_not_yet");
    add_vec(0, 1, 1,  0, 0, 1, 0, 0, "glitch_run_no_retry");

    foreach (vecs[i]) begin
      rst = vecs[i].rst;
      bus.LOCKED_IN = vecs[i].lk;
      edges(vecs[i].cycles);
      check(vecs[i].name, vecs[i].dcm, vecs[i].sys, vecs[i].rdy, vecs[i].fl, vecs[i].rc);
    end

    // Lock never arrives: three timeouts, then sticky FAIL.
    bus.LOCKED_IN = 1'b0;
    apply_reset();
    begin
      int edge_n;
      edge_n = 0;
      for (int k = 1; k <= MAX_RETRIES; k++) begin
        int target;
        target = k * (RST_CYCLES + LOCK_TIMEOUT);
        edges(target - 1 - edge_n);
        edge_n = target - 1;
        check($sformatf("timeout%0d_before", k), 1'b0, 1'b1, 1'b0, 1'b0, RW'(k - 1));
        edges(1);
        edge_n++;
        check($sformatf("timeout%0d_after", k), 1'b1, 1'b1, 1'b0, k == MAX_RETRIES, RW'(k));
      end
    end
    bus.LOCKED_IN = 1'b1;
    edges(50);
    check("fail_sticky", 1'b1, 1'b1, 1'b0, 1'b1, RW'(MAX_RETRIES));
    #2 rst = 1'b1;
    #1 check_reset_vals("fail_async_reset");
    edges(1);
    rst = 1'b0;

    // Asynchronous reset in the middle of STABLE.
    edges(13);
    check("mid_stable", 1'b0, 1'b1, 1'b0, 1'b0, '0);
    #2 rst = 1'b1;
    #1 check_reset_vals("mid_stable_async_reset");
    edges(1);
    rst = 1'b0;
    edges(3);
    check("restart_pulse", 1'b1, 1'b1, 1'b0, 1'b0, '0);
    edges(1);
    check("restart_dcm_release", 1'b0, 1'b1, 1'b0, 1'b0, '0);

    // Randomized lock patterns against the reference model.
    bus.LOCKED_IN = 1'b0;
    apply_reset();
    model_reset();
    begin
      int total;
      total = 0;
      while (total < 20000) begin
        int kind, len;
        logic lv;
        kind = $urandom_range(0, 19);
        if (kind == 0) begin
          rst = 1'b1;
          model_reset();
          edges(1);
          check_reset_vals("random_reset");
          rst = 1'b0;
          total++;
        end else begin
          if (kind <= 3) begin
            lv = 1'b0; len = $urandom_range(900, 1100);
          end else if (kind <= 11) begin
            lv = 1'b1; len = $urandom_range(1, 60);
          end else begin
            lv = 1'b0; len = $urandom_range(1, 3);
          end
          for (int c = 0; c < len; c++) begin
            bus.LOCKED_IN = lv;
            @(posedge clk);
            model_edge(lv);
            #1;
            check_model("random");
          end
          total += len;
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
